// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester per burst; the grant is held until the last beat.
// Optional beat limit with forced release: define RR_BURST_ARB_BURST_LIMIT_EN.
module rr_burst_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDW       = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req_i,
    input  logic           ack_i,
    input  logic           last_i,
    output logic [N-1:0]   gnt_o,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           preempt_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] win_next;
    logic [IDW:0]   idx;
    logic           limit_hit;
    logic           release_beat;
    logic           take;

    // Rotating search starting at ptr_q; the sum is folded once since ptr_q + i < 2N.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!found && req_i[idx[IDW-1:0]]) begin
                found  = 1'b1;
                win_id = idx[IDW-1:0];
            end
        end
    end

    assign win_next     = (win_id == IDW'(N - 1)) ? '0 : win_id + IDW'(1);
    assign release_beat = (state_q == StBusy) && ack_i && (last_i || limit_hit);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        take     = 1'b0;
        unique case (state_q)
            StIdle: begin
                take = found;
            end
            StBusy: begin
                if (release_beat) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (take) begin
            gnt_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
            gnt_id_d = win_id;
            ptr_d    = win_next;
            state_d  = StBusy;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_id_o    = gnt_id_q;

`ifdef RR_BURST_ARB_BURST_LIMIT_EN
    localparam int unsigned CW = $clog2(MAX_BURST);

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          preempt_q, preempt_d;

    // Reaching MAX_BURST-1 counted beats means this non-last beat is the final one allowed.
    assign limit_hit = ack_i && !last_i && (beat_cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        preempt_d  = release_beat && limit_hit;
        if (take || release_beat) begin
            beat_cnt_d = '0;
        end else if ((state_q == StBusy) && ack_i) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign preempt_o = preempt_q;
`else
    logic [31:0] unused_max_burst;

    assign unused_max_burst = MAX_BURST;
    assign limit_hit        = 1'b0;
    assign preempt_o        = 1'b0;
`endif

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Registered round-robin arbiter that shares one downstream resource (bus port, FIFO write side, datapath lane) between N requesters at burst granularity. A grant, once issued, is held until the winning requester's final beat is accepted, so a multi-beat transfer is never interleaved with another requester's beats. It sits between the requester interfaces and the shared resource's valid/accept handshake. It replaces fixed-priority selection wherever starvation of high-index requesters is unacceptable.

## Interface
- N, default 4: number of requesters, 2..32.
- MAX_BURST, default 8: beat limit per grant; used only when the burst-limit feature is compiled in. Must be ≥ 2.
- IDW, default $clog2(N): width of gnt_id_o. Derived; do not override.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised externally to clk.
- req_i  input  N  per-requester request level. A requester holds its bit high from request until its last beat is accepted.
- ack_i  input  1  shared resource accepted one beat from the granted requester this cycle.
- last_i  input  1  the beat accepted this cycle is the final beat of the burst. Qualified by ack_i.
- gnt_o  output  N  registered one-hot grant, or all zeros.
- gnt_valid_o  output  1  equals |gnt_o.
- gnt_id_o  output  IDW  binary index of the granted requester. Holds its last value when gnt_valid_o = 0.
- preempt_o  output  1  one-cycle pulse on a forced release (see Configuration). Constant 0 when the feature is compiled out.

## Operation
- State: IDLE or BUSY. Pointer ptr (IDW bits) marks the highest-priority index. Beat counter beat_cnt exists only with the feature compiled in.
- Selection: the winner is the first set bit of req_i, searching ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
- IDLE with req_i = 0: outputs stay idle.
- IDLE with req_i ≠ 0:
  - Register the winner into gnt_o and gnt_id_o.
  - Set ptr to (winner+1) mod N.
  - Go to BUSY.
- BUSY:
  - gnt_o is frozen, regardless of req_i. Dropping req mid-burst is a protocol violation and does not release the grant.
  - ack_i && !last_i: the beat is counted and the grant is held.
  - ack_i && last_i: release. In the same cycle, run selection over the current req_i with the already-advanced ptr.
    - If a winner exists, the new grant is registered and BUSY continues with no idle cycle.
    - Otherwise gnt_o → 0 and the state returns to IDLE.
  - A requester whose req bit is still set at release is eligible. If it is the only requester, it is re-granted back-to-back.
- last_i without ack_i is ignored. ack_i in IDLE is ignored.
- N not a power of 2: the pointer wraps from N-1 to 0. Indices ≥ N are never granted.

## Timing
- Reset values:
  - gnt_o = 0, gnt_valid_o = 0, gnt_id_o = 0, preempt_o = 0.
  - ptr = 0, state = IDLE, beat_cnt = 0.
- Reset mid-burst: the grant drops asynchronously and no completion is reported.
- Latency from IDLE: req_i sampled high at edge k gives gnt_o valid after edge k.
- Handover: an ack_i && last_i beat sampled at edge k gives the next grant valid after edge k. The resource may accept the new requester's first beat in cycle k+1.
- Selection and release are evaluated from inputs sampled on the same edge. There is no combinational path from req_i, ack_i or last_i to any output.

## Configuration
- Macro: RR_BURST_ARB_BURST_LIMIT_EN.
- Defined:
  - beat_cnt counts accepted beats of the current grant and clears on every new grant.
  - If ack_i && !last_i occurs while beat_cnt = MAX_BURST-1, the grant is forcibly released exactly as for a last beat.
  - preempt_o pulses high for 1 cycle, aligned with the new grant or with the return to IDLE.
  - A preempted requester keeps its req high and competes again from the rotated pointer.
- Undefined:
  - No counter is built and no beat limit applies. The grant is held until ack_i && last_i.
  - preempt_o is tied to 0.

## Test plan
- Reset, then req_i = 4'b1111 with a single-beat burst each grant: grants go 0,1,2,3,0 on consecutive cycles, gnt_id_o follows, and there are no idle cycles.
- req_i = 4'b0100 with no requests from others: grant to 2 one cycle after the request. After a 3-beat burst, req_i = 4'b0101 gives the next grant to 0 (ptr = 3 wraps).
- Requester 1 is in a 5-beat burst and req_i[3] rises at beat 2: gnt_o stays 4'b0010 until the beat carrying last, then becomes 4'b1000 the next cycle.
- Single requester 0 held high through 3 consecutive 2-beat bursts: gnt_o = 4'b0001 continuously and gnt_valid_o never drops.
- Feature defined, MAX_BURST = 4, requester 0 streams 10 beats without last while req_i = 4'b0011: forced release after the 4th accepted beat, preempt_o pulses once, and gnt_o = 4'b0010. Feature undefined: gnt_o stays 4'b0001 for all 10 beats.
- reset_n asserted mid-burst at beat 2: gnt_o = 0 immediately. After release with req_i = 4'b1000, grant to 3 one cycle later and ptr = 0.
